pipeline_hazard_ctrl: RTL and testbench

- Drives the control inputs of the IF/ID, ID/EXE and EXE/MEM pipeline latches: per-stage enables and bubble/flush requests.
- The latches consume these signals; this block produces them.
- Detects load-use hazards (multi-cycle stall), multi-cycle EXE operations (pipeline freeze) and taken branches (squash).
- Instantiated once in the CPU top, between the ID/EXE stage signals and the latch control pins.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// default register-index width and a small sizing helper.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam int HZ_STATE_WIDTH = 2;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_RUN        = 2'd0;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_LOAD_STALL = 2'd1;
  localparam logic [HZ_STATE_WIDTH-1:0] HZ_MC_STALL   = 2'd2;

  typedef enum logic [HZ_STATE_WIDTH-1:0] {
    ST_RUN        = HZ_RUN,
    ST_LOAD_STALL = HZ_LOAD_STALL,
    ST_MC_STALL   = HZ_MC_STALL
  } hz_state_t;

  function automatic int hz_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an ID source register that
// matches the destination of a register-writing load currently in EXE.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = pipeline_hazard_ctrl_pkg::REG_ADDR_WIDTH
) (
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [ADDR_W-1:0] exe_rd,
  input  logic              exe_is_load,
  input  logic              exe_is_write_regs,
  output logic              load_use
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == exe_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == exe_rd);

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = exe_is_load && exe_is_write_regs && (exe_rd != '0) &&
                    (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch controller: stalls on load-use, freezes for multi-cycle EXE
// ops, squashes on taken branches, and counts stalled cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int MC_LATENCY        = 4,
  parameter int PERF_WIDTH        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_en,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] exe_rd,
  input  logic                      exe_is_load,
  input  logic                      exe_is_write_regs,
  input  logic                      exe_is_multicycle,
  input  logic                      exe_branch_taken,
  output logic                      if_en,
  output logic                      id_en,
  output logic                      exe_en,
  output logic                      if_id_flush,
  output logic                      id_exe_bubble,
  output logic                      exe_mem_bubble,
  output logic                      busy,
  output logic [PERF_WIDTH-1:0]     stall_count
);

  import pipeline_hazard_ctrl_pkg::*;

  localparam int CNT_MAX = hz_max(LOAD_STALL_CYCLES, MC_LATENCY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  hz_state_t             state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [PERF_WIDTH-1:0] stall_q;
  logic                  load_use;

  load_use_detect #(
    .ADDR_W(REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .exe_rd           (exe_rd),
    .exe_is_load      (exe_is_load),
    .exe_is_write_regs(exe_is_write_regs),
    .load_use         (load_use)
  );

  // A cleared cpu_en simply holds state, counter and perf count
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      stall_q <= '0;
    end else if (cpu_en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!if_en) stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    if_en          = 1'b1;
    id_en          = 1'b1;
    exe_en         = 1'b1;
    if_id_flush    = 1'b0;
    id_exe_bubble  = 1'b0;
    exe_mem_bubble = 1'b0;

    if (rst || !cpu_en) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (exe_branch_taken) begin
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
          end else if (exe_is_multicycle) begin
            if_en          = 1'b0;
            id_en          = 1'b0;
            exe_en         = 1'b0;
            exe_mem_bubble = 1'b1;
            cnt_nxt        = CNT_W'(MC_LATENCY - 1);
            state_nxt      = ST_MC_STALL;
          end else if (load_use) begin
            if_en         = 1'b0;
            id_en         = 1'b0;
            id_exe_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_nxt   = CNT_W'(LOAD_STALL_CYCLES - 1);
              state_nxt = ST_LOAD_STALL;
            end
          end
        end
        ST_LOAD_STALL: begin
          if_en         = 1'b0;
          id_en         = 1'b0;
          id_exe_bubble = 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = ST_RUN;
          else                  cnt_nxt   = cnt - 1'b1;
        end
        ST_MC_STALL: begin
          // On the last count the multi-cycle op leaves EXE with normal advance outputs
          if (cnt == CNT_W'(1)) begin
            state_nxt = ST_RUN;
          end else begin
            if_en          = 1'b0;
            id_en          = 1'b0;
            exe_en         = 1'b0;
            exe_mem_bubble = 1'b1;
            cnt_nxt        = cnt - 1'b1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign busy        = !rst && (state != ST_RUN);
  assign stall_count = rst ? '0 : stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with default parameters.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [4:0]  id_rs1, id_rs2, exe_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        exe_is_load, exe_is_write_regs, exe_is_multicycle, exe_branch_taken;
  logic        if_en, id_en, exe_en, if_id_flush, id_exe_bubble, exe_mem_bubble, busy;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // {if_en,id_en,exe_en,if_id_flush,id_exe_bubble,exe_mem_bubble,busy}
  logic [6:0] ctl;
  assign ctl = {if_en, id_en, exe_en, if_id_flush, id_exe_bubble, exe_mem_bubble, busy};

  localparam logic [6:0] C_ZERO     = 7'b000_000_0;
  localparam logic [6:0] C_ADV      = 7'b111_000_0;
  localparam logic [6:0] C_ADV_BUSY = 7'b111_000_1;
  localparam logic [6:0] C_LU_RUN   = 7'b001_010_0;
  localparam logic [6:0] C_LU_STALL = 7'b001_010_1;
  localparam logic [6:0] C_MC_RUN   = 7'b000_001_0;
  localparam logic [6:0] C_MC_STALL = 7'b000_001_1;
  localparam logic [6:0] C_BRANCH   = 7'b111_110_0;
  localparam logic [6:0] C_HOLD_BSY = 7'b000_000_1;

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(2), .MC_LATENCY(4), .PERF_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .exe_rd(exe_rd), .exe_is_load(exe_is_load),
    .exe_is_write_regs(exe_is_write_regs),
    .exe_is_multicycle(exe_is_multicycle),
    .exe_branch_taken(exe_branch_taken),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
    .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble),
    .exe_mem_bubble(exe_mem_bubble), .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; exe_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    exe_is_load = 1'b0; exe_is_write_regs = 1'b0;
    exe_is_multicycle = 1'b0; exe_branch_taken = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    exe_is_load = 1'b1; exe_is_write_regs = 1'b1; exe_rd = rd;
    id_rs2 = rd; id_uses_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    cpu_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    cpu_en = 1'b1;
    exe_is_multicycle = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (ctl !== C_ZERO) begin
        n_fail++;
        $display("[TB] FAIL reset_ctl cycle %0d got %b expected %b", i, ctl, C_ZERO);
      end
      n_checks++;
      if (stall_count !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_stall_count got %0d expected 0", stall_count);
      end
      tick();
    end
    rst = 1'b0;
    exe_is_multicycle = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      n_fail++;
      $display("[TB] FAIL reset_release got %b expected %b", ctl, C_ADV);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #1;
    n_checks++;
    if (ctl !== C_LU_RUN) begin
      n_fail++;
      $display("[TB] FAIL load_use_first got %b expected %b", ctl, C_LU_RUN);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (ctl !== C_LU_STALL) begin
      n_fail++;
      $display("[TB] FAIL load_use_second got %b expected %b", ctl, C_LU_STALL);
    end
    tick();
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      n_fail++;
      $display("[TB] FAIL load_use_done got %b expected %b", ctl, C_ADV);
    end
    n_checks++;
    if (stall_count !== 32'd2) begin
      n_fail++;
      $display("[TB] FAIL load_use_count got %0d expected 2", stall_count);
    end
    // rd of zero never stalls
    set_load_use(5'd0);
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      n_fail++;
      $display("[TB] FAIL load_use_rd0 got %b expected %b", ctl, C_ADV);
    end
    // matching rs1 that is not read must not stall
    clear_inputs();
    exe_is_load = 1'b1; exe_is_write_regs = 1'b1; exe_rd = 5'd7;
    id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      n_fail++;
      $display("[TB] FAIL load_use_rs1_unused got %b expected %b", ctl, C_ADV);
    end
    id_uses_rs1 = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_LU_RUN) begin
      n_fail++;
      $display("[TB] FAIL load_use_rs1 got %b expected %b", ctl, C_LU_RUN);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (stall_count !== 32'd3) begin
      n_fail++;
      $display("[TB] FAIL load_use_count_rs1 got %0d expected 3", stall_count);
    end
  endtask

  task automatic test_multicycle();
    logic [6:0] exp_seq [4];
    int         cyc;
    exp_seq[0] = C_MC_RUN; exp_seq[1] = C_MC_STALL;
    exp_seq[2] = C_MC_STALL; exp_seq[3] = C_ADV_BUSY;
    do_reset();
    exe_is_multicycle = 1'b1;
    cyc = 0;
    #1;
    while (exe_en !== 1'b1 && cyc < 10) begin
      if (cyc < 4) begin
        n_checks++;
        if (ctl !== exp_seq[cyc]) begin
          n_fail++;
          $display("[TB] FAIL mc_seq cycle %0d got %b expected %b", cyc, ctl, exp_seq[cyc]);
        end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 3) begin
      n_fail++;
      $display("[TB] FAIL mc_freeze_len got %0d expected 3", cyc);
    end
    n_checks++;
    if (ctl !== C_ADV_BUSY) begin
      n_fail++;
      $display("[TB] FAIL mc_release got %b expected %b", ctl, C_ADV_BUSY);
    end
    tick();
    exe_is_multicycle = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      n_fail++;
      $display("[TB] FAIL mc_after got %b expected %b", ctl, C_ADV);
    end
    n_checks++;
    if (stall_count !== 32'd3) begin
      n_fail++;
      $display("[TB] FAIL mc_count got %0d expected 3", stall_count);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_load_use(5'd9);
    exe_branch_taken = 1'b1;
    exe_is_multicycle = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_BRANCH) begin
      n_fail++;
      $display("[TB] FAIL branch_ctl got %b expected %b", ctl, C_BRANCH);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      n_fail++;
      $display("[TB] FAIL branch_after got %b expected %b", ctl, C_ADV);
    end
    n_checks++;
    if (stall_count !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL branch_count got %0d expected 0", stall_count);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    set_load_use(5'd3);
    tick();
    clear_inputs();
    cpu_en = 1'b0;
    exe_is_multicycle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl !== C_HOLD_BSY) begin
        n_fail++;
        $display("[TB] FAIL freeze_ctl cycle %0d got %b expected %b", i, ctl, C_HOLD_BSY);
      end
      tick();
    end
    n_checks++;
    if (stall_count !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL freeze_count got %0d expected 1", stall_count);
    end
    cpu_en = 1'b1;
    exe_is_multicycle = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_LU_STALL) begin
      n_fail++;
      $display("[TB] FAIL freeze_resume got %b expected %b", ctl, C_LU_STALL);
    end
    tick();
    n_checks++;
    if (ctl !== C_ADV) begin
      n_fail++;
      $display("[TB] FAIL freeze_run got %b expected %b", ctl, C_ADV);
    end
    n_checks++;
    if (stall_count !== 32'd2) begin
      n_fail++;
      $display("[TB] FAIL freeze_count_end got %0d expected 2", stall_count);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    exe_is_multicycle = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if (ctl !== C_MC_STALL) begin
      n_fail++;
      $display("[TB] FAIL midrst_pre got %b expected %b", ctl, C_MC_STALL);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_ZERO) begin
      n_fail++;
      $display("[TB] FAIL midrst_during got %b expected %b", ctl, C_ZERO);
    end
    tick();
    rst = 1'b0;
    exe_is_multicycle = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      n_fail++;
      $display("[TB] FAIL midrst_after got %b expected %b", ctl, C_ADV);
    end
    n_checks++;
    if (stall_count !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL midrst_count got %0d expected 0", stall_count);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    cpu_en = 1'b0;
    #2;
    test_reset();
    test_load_use();
    test_multicycle();
    test_branch_priority();
    test_freeze();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
